team_06_serial_deser: RTL

Parametrised serial-to-parallel receiver for serial streams from the ESP/ADC side, such as SPI-like byte streams and sample words. Internally generates the serial bit clock from clk and frames words with an active-low chip select. Assembles DATA_W-bit words MSB- or LSB-first and buffers them in a small FIFO behind a valid/ready interface. Sits between the off-chip serial pins and the team's downstream audio/data path.

---
 rtl/team_06_serial_deser.sv | 294 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/team_06_serial_deser.sv
// -----------------------------------------------------------------------------
// team_06_serial_deser
//
// Serial-to-parallel receiver for SPI-like streams from the ESP/ADC side.
// The block generates its own bit clock (sclk_out) from clk. It frames words
// with an active-low chip select. It assembles DATA_W-bit words MSB- or
// LSB-first and queues them in a small FIFO behind a valid/ready interface.
//
// Optional build macro: TEAM_06_DESER_PARITY_EN
//   When defined, each frame carries one trailing even-parity bit after the
//   data bits. A word with a parity mismatch is dropped and parity_err pulses.
//   When undefined, frames carry no parity bit and there is no parity_err port.
//
// Parameters:
//   DATA_W      bits per word (2..32)
//   CLK_DIV     clk cycles per sclk_out half-period (>=1)
//   FIFO_DEPTH  output FIFO entries (power of 2, >=2)
//   MSB_FIRST   1: first received bit lands in data_out[DATA_W-1]
//               0: first received bit lands in data_out[0]
//
// Ports:
//   clk           system clock
//   rst           asynchronous, active-high reset
//   en            block enable; 0 holds the divider and FSM in IDLE
//   cs_n          frame select, active low
//   serial_in     serial data, captured on the sclk_out rising tick
//   sclk_out      generated serial clock to the sender
//   data_out      FIFO head word
//   valid_out     FIFO non-empty
//   ready_in      consumer accepts head word when valid_out & ready_in
//   fifo_count    words currently held
//   overflow      sticky flag: a completed word was dropped on a full FIFO
//   clr_overflow  clears overflow (a drop in the same cycle wins)
//   frame_err     one-cycle pulse: cs_n rose with a partial word in progress
//   parity_err    (parity build only) one-cycle pulse on a parity mismatch
// -----------------------------------------------------------------------------
module team_06_serial_deser #(
  parameter int DATA_W     = 8,
  parameter int CLK_DIV    = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int MSB_FIRST  = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic                          cs_n,
  input  logic                          serial_in,
  output logic                          sclk_out,
  output logic [DATA_W-1:0]             data_out,
  output logic                          valid_out,
  input  logic                          ready_in,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  input  logic                          clr_overflow,
  output logic                          frame_err
`ifdef TEAM_06_DESER_PARITY_EN
  ,
  output logic                          parity_err
`endif
);

  // ---------------------------------------------------------------------------
  // Derived sizes
  // ---------------------------------------------------------------------------
`ifdef TEAM_06_DESER_PARITY_EN
  // The parity bit occupies one extra counter slot after the data bits.
  localparam int LAST_BIT = DATA_W;
`else
  localparam int LAST_BIT = DATA_W - 1;
`endif
  localparam int CNT_W = $clog2(LAST_BIT + 1);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int FC_W  = PTR_W + 1;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LAST_BIT);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [FC_W-1:0]  FULL_CNT = FC_W'(FIFO_DEPTH);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // Receiver state
  // ---------------------------------------------------------------------------
  state_t              state_reg;
  logic [DIV_W-1:0]    div_cnt_reg;
  logic                sclk_reg;
  logic                sclk_dly_reg;
  logic [CNT_W-1:0]    bit_cnt_reg;
  logic [DATA_W-1:0]   shift_reg;
  logic                frame_err_reg;
  logic                parity_err_reg;

  logic                rise_tick;
  logic                in_frame;
  logic                capture;
  logic                last_bit;
  logic                word_done;
  logic [DATA_W-1:0]   shift_next;
  logic                push_req;
  logic [DATA_W-1:0]   push_data;
  logic                parity_bad;

  // ---------------------------------------------------------------------------
  // FIFO state
  // ---------------------------------------------------------------------------
  logic [PTR_W-1:0]                   wr_ptr_reg;
  logic [PTR_W-1:0]                   rd_ptr_reg;
  logic [FC_W-1:0]                    fifo_count_reg;
  logic                               overflow_reg;
  logic [FIFO_DEPTH-1:0][DATA_W-1:0]  mem_q;

  logic                               fifo_valid;
  logic                               fifo_full;
  logic                               pop;
  logic                               push_ok;
  logic                               drop;

  // ---------------------------------------------------------------------------
  // Capture decode
  // ---------------------------------------------------------------------------
  always_comb begin
    rise_tick = sclk_reg & ~sclk_dly_reg;

    // A capture only counts while the frame is still open in this cycle.
    // An abort in the same cycle wins over the tick.
    in_frame  = (state_reg == ST_SHIFT) & en & ~cs_n;
    capture   = in_frame & rise_tick;
    last_bit  = (bit_cnt_reg == LAST_CNT);
    word_done = capture & last_bit;

    if (MSB_FIRST != 0) begin
      shift_next = {shift_reg[DATA_W-2:0], serial_in};
    end else begin
      shift_next = {serial_in, shift_reg[DATA_W-1:1]};
    end

`ifdef TEAM_06_DESER_PARITY_EN
    // The final capture is the parity bit. The data word is already complete
    // in shift_reg. With even parity, the parity bit equals the XOR of the
    // data bits.
    parity_bad = word_done & ((^shift_reg) != serial_in);
    push_req   = word_done & ~parity_bad;
    push_data  = shift_reg;
`else
    parity_bad = 1'b0;
    push_req   = word_done;
    push_data  = shift_next;
`endif
  end

  // ---------------------------------------------------------------------------
  // Frame FSM, bit-clock divider and shift register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      div_cnt_reg    <= '0;
      sclk_reg       <= 1'b0;
      sclk_dly_reg   <= 1'b0;
      bit_cnt_reg    <= '0;
      shift_reg      <= '0;
      frame_err_reg  <= 1'b0;
      parity_err_reg <= 1'b0;
    end else begin
      sclk_dly_reg   <= sclk_reg;
      frame_err_reg  <= 1'b0;
      parity_err_reg <= parity_bad;

      case (state_reg)
        ST_IDLE: begin
          div_cnt_reg <= '0;
          sclk_reg    <= 1'b0;
          bit_cnt_reg <= '0;
          shift_reg   <= '0;
          if (en && !cs_n) begin
            state_reg <= ST_SHIFT;
          end
        end

        ST_SHIFT: begin
          if (!en || cs_n) begin
            // Abort the frame and discard any partial word. Words already
            // queued in the FIFO are kept. Only a chip-select rise mid-word
            // counts as a framing error; disabling the block does not.
            state_reg     <= ST_IDLE;
            div_cnt_reg   <= '0;
            sclk_reg      <= 1'b0;
            bit_cnt_reg   <= '0;
            shift_reg     <= '0;
            frame_err_reg <= cs_n && (bit_cnt_reg != '0);
          end else begin
            if (div_cnt_reg == DIV_LAST) begin
              div_cnt_reg <= '0;
              sclk_reg    <= ~sclk_reg;
            end else begin
              div_cnt_reg <= div_cnt_reg + DIV_W'(1);
            end

            if (capture) begin
              if (last_bit) begin
                // The word leaves through push_data at this same edge, so
                // the next word can start on the very next tick.
                bit_cnt_reg <= '0;
                shift_reg   <= '0;
              end else begin
                bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
                shift_reg   <= shift_next;
              end
            end
          end
        end

        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output FIFO
  // ---------------------------------------------------------------------------
  // Pop is resolved before push, so a full FIFO that pops in the same cycle
  // still accepts the new word.
  always_comb begin
    fifo_valid = (fifo_count_reg != '0);
    fifo_full  = (fifo_count_reg == FULL_CNT);
    pop        = fifo_valid & ready_in;
    push_ok    = push_req & (~fifo_full | pop);
    drop       = push_req & fifo_full & ~pop;
  end

  // Each storage entry is a separate register. The head is selected by the
  // read pointer, so data_out holds still while the consumer stalls.
  genvar gi;
  generate
    for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
      logic [DATA_W-1:0] entry_reg;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          entry_reg <= '0;
        end else if (push_ok && (wr_ptr_reg == PTR_W'(gi))) begin
          entry_reg <= push_data;
        end
      end

      assign mem_q[gi] = entry_reg;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      fifo_count_reg <= '0;
      overflow_reg   <= 1'b0;
    end else begin
      // FIFO_DEPTH is a power of two, so the pointers wrap naturally.
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      fifo_count_reg <= fifo_count_reg + FC_W'(push_ok) - FC_W'(pop);

      // A drop in the same cycle as the clear keeps the flag set.
      if (drop) begin
        overflow_reg <= 1'b1;
      end else if (clr_overflow) begin
        overflow_reg <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign sclk_out   = sclk_reg;
  assign data_out   = mem_q[rd_ptr_reg];
  assign valid_out  = fifo_valid;
  assign fifo_count = fifo_count_reg;
  assign overflow   = overflow_reg;
  assign frame_err  = frame_err_reg;
`ifdef TEAM_06_DESER_PARITY_EN
  assign parity_err = parity_err_reg;
`endif

endmodule
